// File: rtl/id_scan_pkg.sv
// Shared types and character-class helpers for the identifier scan controller.
`timescale 1ns/1ps
package id_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALPHA,
        S_NUM
    } rec_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_STREAM,
        C_RESP
    } ctrl_state_t;

    // Plain ASCII letters only; bytes with bit 7 set never qualify.
    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/id_recognizer.sv
// Three-state identifier recognizer: letter starts an identifier, digits after a
// letter extend it into NUM; anything else drops back to IDLE.
`timescale 1ns/1ps
module id_recognizer
    import id_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] char,
    output rec_state_t state,
    output rec_state_t next_state,
    output logic       hit
);

    rec_state_t r_state;
    rec_state_t w_next;

    // Transition function of the recognizer for the presented character.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = is_letter(char) ? S_ALPHA : S_IDLE;
            S_ALPHA: begin
                if (is_digit(char))       w_next = S_NUM;
                else if (is_letter(char)) w_next = S_ALPHA;
                else                      w_next = S_IDLE;
            end
            S_NUM: begin
                if (is_letter(char))      w_next = S_ALPHA;
                else if (is_digit(char))  w_next = S_NUM;
                else                      w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register: clear wins over advance; holds when neither is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else if (clr)
            r_state <= S_IDLE;
        else if (en)
            r_state <= w_next;
    end

    assign state      = r_state;
    assign next_state = w_next;
    assign hit        = en && (r_state == S_ALPHA) && (w_next == S_NUM);

endmodule

// File: rtl/id_scan_ctrl.sv
// Round-robin front end sharing one identifier recognizer between N_REQ string
// requesters; the grant is held for a whole string and one response is returned.
`timescale 1ns/1ps
module id_scan_ctrl
    import id_scan_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_char,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [CNT_W-1:0]   rsp_count,
    output logic               rsp_match_end,
    output logic               busy
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [ID_W-1:0]  r_grant;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ID_W-1:0]  r_rsp_id;
    logic [CNT_W-1:0] r_rsp_count;
    logic             r_rsp_match_end;

    logic [ID_W-1:0]  w_pick;
    logic             w_any;
    logic             w_g_valid;
    logic             w_g_last;
    logic [7:0]       w_g_char;
    logic             w_accept;
    logic             w_rec_clr;
    logic             w_hit;
    logic [CNT_W-1:0] w_count_next;
    rec_state_t       w_rec_state;
    rec_state_t       w_rec_next;

    // Rotating priority search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned idx;
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any  = 1'b1;
                w_pick = ID_W'(idx);
            end
        end
    end

    // Route the granted requester's lane onto the recognizer.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_char  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_g_valid = req_valid[i];
                w_g_last  = req_last[i];
                w_g_char  = req_char[8*i +: 8];
            end
        end
    end

    // Controller next-state and ready generation.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        w_accept     = 1'b0;
        w_rec_clr    = 1'b0;
        unique case (r_state)
            C_IDLE: begin
                if (w_any) begin
                    w_rec_clr    = 1'b1;
                    w_next_state = C_STREAM;
                end
            end
            C_STREAM: begin
                for (int unsigned i = 0; i < N_REQ; i++)
                    req_ready[i] = (r_grant == ID_W'(i));
                w_accept = w_g_valid;
                if (w_g_valid && w_g_last)
                    w_next_state = C_RESP;
            end
            C_RESP: begin
                if (rsp_ready)
                    w_next_state = C_IDLE;
            end
            default: w_next_state = C_IDLE;
        endcase
    end

    id_recognizer u_rec (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_rec_clr),
        .en         (w_accept),
        .char       (w_g_char),
        .state      (w_rec_state),
        .next_state (w_rec_next),
        .hit        (w_hit)
    );

    // Saturating identifier count including the current beat's hit.
    always_comb begin
        w_count_next = r_count;
        if (w_hit && (r_count != '1))
            w_count_next = r_count + CNT_W'(1);
    end

    // Controller state, grant, round-robin pointer, counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= C_IDLE;
            r_grant         <= '0;
            r_rr_ptr        <= '0;
            r_count         <= '0;
            r_rsp_id        <= '0;
            r_rsp_count     <= '0;
            r_rsp_match_end <= 1'b0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                C_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_count <= '0;
                    end
                end
                C_STREAM: begin
                    if (w_accept) begin
                        r_count <= w_count_next;
                        if (w_g_last) begin
                            r_rsp_id        <= r_grant;
                            r_rsp_count     <= w_count_next;
                            r_rsp_match_end <= (w_rec_next == S_NUM);
                        end
                    end
                end
                C_RESP: begin
                    if (rsp_ready)
                        r_rr_ptr <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid     = (r_state == C_RESP);
    assign rsp_id        = r_rsp_id;
    assign rsp_count     = r_rsp_count;
    assign rsp_match_end = r_rsp_match_end;
    assign busy          = (r_state != C_IDLE);

    // The recognizer is frozen while a response waits, so it must agree with the latched flag.
    a_match_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == C_RESP) |-> ((w_rec_state == S_NUM) == r_rsp_match_end));

endmodule
